controle_ld_sd: RTL and testbench
=================================

CONTROLE_LD_SD -- requirements
Module: controle_ld_sd

Interface
REQ-001 The block SHALL have parameter BITS, default 63, giving the MSB index of the data and address paths.
REQ-002 The block SHALL have parameter PC_RESET, default 0, giving the PC value loaded on reset and on restart.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, a run request that is sampled only in IDLE or HALT.
REQ-006 The block SHALL have port instr, input, 32 bits, the instruction word from instruction memory for the current pc.
REQ-007 The block SHALL have port pc, output, BITS+1 bits, the instruction memory address.
REQ-008 The block SHALL have port enable, output, 1 bit, the datapath operation strobe.
REQ-009 The block SHALL have port load_store, output, 1 bit: 1 = load, 0 = store.
REQ-010 The block SHALL have ports ra, rb and rw, outputs, 5 bits each: register selects, with ra = store-data source, rb = base-address source, rw = load destination.
REQ-011 The block SHALL have port dataIn, output, BITS+1 bits, the sign-extended offset driven to the datapath adder.
REQ-012 The block SHALL have ports busy, done and illegal, outputs, 1 bit each: status flags.
REQ-013 The block SHALL have port instr_count, output, 16 bits, the count of executed instructions (see Configuration).

Function
REQ-014 The FSM SHALL have exactly six states: IDLE, FETCH, DECODE, EXEC, HALT and ERROR.
REQ-015 In IDLE, start=1 SHALL move the FSM to FETCH; start=0 SHALL keep it in IDLE.
REQ-016 In FETCH, the 32-bit instruction register IR SHALL capture instr at the clock edge, and the FSM SHALL then go to DECODE.
REQ-017 DECODE, with IR=32'h00000000, SHALL go to HALT.
REQ-018 DECODE, with opcode IR[6:0]=7'b0000011 and funct3 IR[14:12]=3'b011 (LD), SHALL go to EXEC as a load.
REQ-019 DECODE, with opcode 7'b0100011 and funct3 3'b011 (SD), SHALL go to EXEC as a store.
REQ-020 DECODE, for any other IR, SHALL go to ERROR.
REQ-021 ra, rb, rw, dataIn and load_store SHALL be registered when leaving DECODE and held stable through EXEC.
REQ-022 Field mapping: rb=IR[19:15]; ra=IR[24:20]; rw=IR[11:7] for LD and 5'd0 for SD.
REQ-023 For LD, dataIn SHALL equal IR[31:20] sign-extended to BITS+1 bits.
REQ-024 For SD, dataIn SHALL equal {IR[31:25],IR[11:7]} sign-extended to BITS+1 bits.
REQ-025 enable SHALL be 1 for exactly the one EXEC cycle and 0 in every other state.
REQ-026 On leaving EXEC, pc SHALL become pc+4 modulo 2^(BITS+1), and the FSM SHALL go to FETCH.
REQ-027 Steady-state throughput SHALL be one instruction per 3 cycles (FETCH, DECODE, EXEC).
REQ-028 busy SHALL be 1 in FETCH, DECODE and EXEC, and 0 otherwise.
REQ-029 In HALT, done SHALL be 1 and pc SHALL hold the halting address.
REQ-030 In HALT, start=1 SHALL load pc=PC_RESET and move the FSM to FETCH.
REQ-031 In ERROR, illegal SHALL be 1 and pc SHALL hold the address of the offending instruction.
REQ-032 ERROR SHALL be left only by reset; start SHALL be ignored there.
REQ-033 start asserted while busy SHALL be ignored, with no queuing.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL force: state=IDLE, pc=PC_RESET, IR=0, ra=rb=rw=0, dataIn=0, load_store=0, enable=0, busy=done=illegal=0, instr_count=0.
REQ-035 reset SHALL take priority over start and over every state transition.
REQ-036 Reset asserted during EXEC SHALL deassert enable from the next cycle, and no pc increment SHALL occur.

Configuration
REQ-037 With macro CONTROLE_INSTR_COUNTER_EN defined, instr_count SHALL increment by 1 on every EXEC cycle and saturate at 16'hFFFF.
REQ-038 instr_count SHALL be cleared only by reset; restart from HALT SHALL NOT clear it.
REQ-039 With CONTROLE_INSTR_COUNTER_EN undefined, instr_count SHALL be tied to 16'h0000, and no counter register SHALL be synthesised.

Verification
REQ-040 Reset then start with instr=32'h00813083 (LD x1,8(x2)) -> EXEC cycle 3 clocks after start shows enable=1, load_store=1, rb=2, rw=1, dataIn=8; next cycle pc=4.
REQ-041 instr=32'hFE313C23 (SD x3,-8(x2)) -> enable=1, load_store=0, rb=2, ra=3, dataIn=64'hFFFF_FFFF_FFFF_FFF8.
REQ-042 Program LD, SD, 32'h0 at pc 0/4/8 -> exactly two enable pulses, then done=1 with pc=8; with the macro defined, instr_count=2.
REQ-043 instr=32'h00000033 at pc=0 -> illegal=1 and pc=0; a start pulse leaves illegal=1; reset clears illegal to 0.
REQ-044 Assert reset on the EXEC cycle of an LD -> next cycle enable=0, pc=PC_RESET, state IDLE; start pulses during FETCH/DECODE are ignored.

Source files
------------

// File: rtl/controle_ld_sd.sv
// Load/store sequencer: fetches an instruction, decodes LD/SD into datapath controls, and strobes one EXEC cycle.
// Optional feature: define CONTROLE_INSTR_COUNTER_EN to build the saturating executed-instruction counter.
module controle_ld_sd #(
  parameter int              BITS     = 63,
  parameter logic [BITS:0]   PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instr,
  output logic [BITS:0]     pc,
  output logic              enable,
  output logic              load_store,
  output logic [4:0]        ra,
  output logic [4:0]        rb,
  output logic [4:0]        rw,
  output logic [BITS:0]     dataIn,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT, ERROR} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_DWORD = 3'b011;

  state_t      state;
  logic [31:0] ir;

  logic          is_ld;
  logic          is_sd;
  logic [BITS:0] imm_ld;
  logic [BITS:0] imm_sd;

  always_comb begin
    is_ld  = (ir[6:0] == OP_LOAD)  && (ir[14:12] == F3_DWORD);
    is_sd  = (ir[6:0] == OP_STORE) && (ir[14:12] == F3_DWORD);
    imm_ld = {{(BITS - 11){ir[31]}}, ir[31:20]};
    imm_sd = {{(BITS - 11){ir[31]}}, ir[31:25], ir[11:7]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      ir         <= '0;
      ra         <= '0;
      rb         <= '0;
      rw         <= '0;
      dataIn     <= '0;
      load_store <= 1'b0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          ir    <= instr;
          state <= DECODE;
        end
        DECODE: begin
          if (ir == 32'h0000_0000) begin
            state <= HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (is_ld || is_sd) begin
            // Controls are captured here so they stay stable for the whole EXEC cycle.
            rb         <= ir[19:15];
            ra         <= ir[24:20];
            rw         <= is_ld ? ir[11:7] : 5'd0;
            dataIn     <= is_ld ? imm_ld : imm_sd;
            load_store <= is_ld;
            enable     <= 1'b1;
            state      <= EXEC;
          end else begin
            state   <= ERROR;
            busy    <= 1'b0;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          enable <= 1'b0;
          pc     <= pc + (BITS + 1)'(4);
          state  <= FETCH;
        end
        HALT: begin
          if (start) begin
            pc    <= PC_RESET;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONTROLE_INSTR_COUNTER_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if ((state == EXEC) && (count_q != 16'hFFFF))
      count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_controle_ld_sd.sv
// Scoreboard bench for controle_ld_sd: expected EXEC controls are queued at issue, a monitor pops them on each enable pulse.
module tb_controle_ld_sd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        enable;
  logic        load_store;
  logic [4:0]  ra, rb, rw;
  logic [63:0] dataIn;
  logic        busy, done, illegal;
  logic [15:0] instr_count;

  controle_ld_sd dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .enable(enable), .load_store(load_store), .ra(ra), .rb(rb), .rw(rw),
    .dataIn(dataIn), .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

`ifdef CONTROLE_INSTR_COUNTER_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  localparam logic [31:0] I_LD1 = 32'h0081_3083; // LD x1,8(x2)
  localparam logic [31:0] I_SD1 = 32'hFE31_3C23; // SD x3,-8(x2)
  localparam logic [31:0] I_LD2 = 32'hFF03_B283; // LD x5,-16(x7)
  localparam logic [31:0] I_SD2 = 32'h7FF0_BFA3; // SD x31,2047(x1)
  localparam logic [31:0] I_LW  = 32'h0081_2083; // LW x1,8(x2): unsupported width
  localparam logic [31:0] I_ADD = 32'h0000_0033;

  logic [31:0] imem [0:7];

  always_comb begin
    instr = 32'h0;
    if (pc[63:5] == '0) instr = imem[pc[4:2]];
  end

  typedef struct packed {
    logic [63:0] pc;
    logic        ls;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   n_pulse = 0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] p, input logic ls, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] w, input logic [63:0] d);
    exp_t e;
    e = '{pc: p, ls: ls, ra: a, rb: b, rw: w, data: d};
    sb.push_back(e);
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
    return (CNT_ON != 0) ? 64'(n) : 64'd0;
  endfunction

  // Monitor: every enable pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (enable === 1'b1) begin
      check("enable_single_cycle", {63'd0, prev_en}, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_exec: enable=1 at pc %0h with no expected entry", pc);
      end else begin
        e = sb.pop_front();
        check("exec_pc", pc, e.pc);
        check("exec_load_store", {63'd0, load_store}, {63'd0, e.ls});
        check("exec_ra", {59'd0, ra}, {59'd0, e.ra});
        check("exec_rb", {59'd0, rb}, {59'd0, e.rb});
        check("exec_rw", {59'd0, rw}, {59'd0, e.rw});
        check("exec_dataIn", dataIn, e.data);
        check("exec_busy", {63'd0, busy}, 64'd1);
      end
      n_pulse++;
    end
    prev_en = enable;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // which: 0 = done, 1 = illegal
  task automatic wait_flag(input string name, input int which, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? done : illegal;
    end
    check(name, {63'd0, seen}, 64'd1);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 8; i++) imem[i] = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_imem();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pc", pc, 64'd0);
    check("rst_enable", {63'd0, enable}, 64'd0);
    check("rst_flags", {61'd0, busy, done, illegal}, 64'd0);
    check("rst_regs", {49'd0, load_store, ra, rb, rw}, 64'd0);
    check("rst_dataIn", dataIn, 64'd0);
    check("rst_count", {48'd0, instr_count}, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", {62'd0, busy, done}, 64'd0);

    // Program A: four mixed loads/stores then halt, with latency check
    imem[0] = I_LD1; imem[1] = I_SD1; imem[2] = I_LD2; imem[3] = I_SD2;
    push(64'd0,  1'b1, 5'd8,  5'd2, 5'd1, 64'd8);
    push(64'd4,  1'b0, 5'd3,  5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    push(64'd8,  1'b1, 5'd16, 5'd7, 5'd5, 64'hFFFF_FFFF_FFFF_FFF0);
    push(64'd12, 1'b0, 5'd31, 5'd1, 5'd0, 64'h0000_0000_0000_07FF);
    n_pulse = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("latency_enable", {63'd0, enable}, 64'd1);
    @(negedge clk);
    check("pc_after_exec", pc, 64'd4);
    check("enable_drop", {63'd0, enable}, 64'd0);
    wait_flag("progA_done", 0, 60);
    check("progA_pc", pc, 64'd16);
    check("progA_busy", {63'd0, busy}, 64'd0);
    check("progA_pulses", 64'(n_pulse), 64'd4);
    check("progA_sb_empty", 64'(sb.size()), 64'd0);
    check("progA_count", {48'd0, instr_count}, exp_cnt(4));

    // Program B: restart from HALT with start held through FETCH/DECODE
    clear_imem();
    imem[0] = I_LD1; imem[1] = I_SD1;
    push(64'd0, 1'b1, 5'd8, 5'd2, 5'd1, 64'd8);
    push(64'd4, 1'b0, 5'd3, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    n_pulse = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("restart_state", {pc[61:0], busy, done}, 64'd2);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_flag("progB_done", 0, 40);
    check("progB_pc", pc, 64'd8);
    check("progB_pulses", 64'(n_pulse), 64'd2);
    check("progB_count", {48'd0, instr_count}, exp_cnt(6));
    repeat (4) @(negedge clk);
    check("progB_stays_halted", {61'd0, busy, done, illegal}, 64'd2);

    // Illegal instruction at pc 0; start ignored in ERROR, reset clears it
    do_reset();
    @(negedge clk);
    check("count_cleared", {48'd0, instr_count}, 64'd0);
    clear_imem();
    imem[0] = I_ADD;
    n_pulse = 0;
    pulse_start();
    wait_flag("illegal_seen", 1, 20);
    check("illegal_pc", pc, 64'd0);
    check("illegal_status", {62'd0, busy, done}, 64'd0);
    pulse_start();
    repeat (4) @(negedge clk);
    check("illegal_sticky", {61'd0, busy, done, illegal}, 64'd1);
    check("illegal_no_exec", 64'(n_pulse), 64'd0);
    do_reset();
    @(negedge clk);
    check("illegal_cleared", {63'd0, illegal}, 64'd0);

    // Unsupported width after a valid load: ERROR holds the offending address
    clear_imem();
    imem[0] = I_LD1; imem[1] = I_LW;
    push(64'd0, 1'b1, 5'd8, 5'd2, 5'd1, 64'd8);
    n_pulse = 0;
    pulse_start();
    wait_flag("lw_illegal", 1, 30);
    check("lw_pc", pc, 64'd4);
    check("lw_pulses", 64'(n_pulse), 64'd1);

    // Reset landing on the EXEC cycle of a load
    do_reset();
    clear_imem();
    imem[0] = I_LD2;
    push(64'd0, 1'b1, 5'd16, 5'd7, 5'd5, 64'hFFFF_FFFF_FFFF_FFF0);
    n_pulse = 0;
    pulse_start();
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = enable;
      end
      check("exec_reached", {63'd0, seen}, 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_exec_enable", {63'd0, enable}, 64'd0);
    check("rst_exec_pc", pc, 64'd0);
    check("rst_exec_regs", {48'd0, busy, load_store, ra, rb, rw}, 64'd0);
    check("rst_exec_dataIn", dataIn, 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_exec_idle", {pc[60:0], busy, done, enable}, 64'd0);
    check("rst_exec_pulses", 64'(n_pulse), 64'd1);

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
